// File: rtl/clock_phase_align.sv
// Fine-phase deskew controller: steps an MMCM/DCM phase shifter until the sampled
// input clock shows a 0->1 transition, then applies a signed offset.
module clock_phase_align #(
   parameter string DEVICE     = "7SERIES",
   parameter int    PS_MAX     = (DEVICE == "SPARTAN6") ? 255 : 1120,
   parameter int    PW         = 12,
   parameter int    SAMPLES    = 64,
   parameter int    SETTLE     = 16,
   parameter int    OFFSET     = 0,
   parameter int    PS_TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          locked_i,
   input  logic          sample_i,
   output logic          psen,
   output logic          psincdec,
   input  logic          psdone,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [1:0]    fail_code,
   output logic [PW-1:0] phase_o
);

   localparam int   ABS_OFF = (OFFSET < 0) ? -OFFSET : OFFSET;
   localparam int   CW      = $clog2(PS_TIMEOUT + SETTLE + SAMPLES + 2);
   localparam int   SW      = $clog2(PS_MAX + 2);
   localparam int   OW      = $clog2(ABS_OFF + 2);
   localparam int   NW      = $clog2(SAMPLES + 1);
   localparam logic OFF_DIR = (OFFSET > 0) ? 1'b1 : 1'b0;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WAIT_LOCK = 4'd1,
      S_SETTLE    = 4'd2,
      S_SAMPLE    = 4'd3,
      S_DECIDE    = 4'd4,
      S_STEP      = 4'd5,
      S_WAIT_PS   = 4'd6,
      S_DONE      = 4'd7,
      S_FAIL      = 4'd8
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NW-1:0] ones_q, ones_d;
   logic [SW-1:0] srch_q, srch_d;
   logic [OW-1:0] off_q, off_d;
   logic          offph_q, offph_d;
   logic          prevz_q, prevz_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [1:0]    code_q, code_d;
   logic          psen_q, psen_d, psincdec_q, psincdec_d;
   logic          busy_q, busy_d, done_q, done_d, fail_q, fail_d;
   logic          vote_s, lock_lost_s;

   assign vote_s      = (ones_q > NW'(SAMPLES / 2));
   assign lock_lost_s = !locked_i && (state_q == S_SETTLE || state_q == S_SAMPLE ||
                                      state_q == S_DECIDE || state_q == S_STEP ||
                                      state_q == S_WAIT_PS);

   // Next-state logic; lock loss overrides the normal transition but keeps a phase update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      srch_d  = srch_q;
      off_d   = off_q;
      offph_d = offph_q;
      prevz_d = prevz_q;
      phase_d = phase_q;
      code_d  = code_q;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_d = S_WAIT_LOCK;
               phase_d = '0;
               code_d  = 2'b00;
               srch_d  = '0;
               offph_d = 1'b0;
               prevz_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_WAIT_LOCK: begin
            if (locked_i) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = S_SAMPLE;
               cnt_d   = '0;
               ones_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1'b1);
            end
         end
         S_SAMPLE: begin
            ones_d = ones_q + {{(NW-1){1'b0}}, sample_i};
            if (cnt_q == CW'(SAMPLES - 1)) begin
               state_d = S_DECIDE;
            end else begin
               cnt_d = cnt_q + CW'(1'b1);
            end
         end
         S_DECIDE: begin
            prevz_d = !vote_s;
            if (vote_s && prevz_q) begin
               if (ABS_OFF == 0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_STEP;
                  offph_d = 1'b1;
                  off_d   = OW'(ABS_OFF);
               end
            end else if (srch_q == SW'(PS_MAX)) begin
               state_d = S_FAIL;
               code_d  = 2'b01;
            end else begin
               state_d = S_STEP;
               srch_d  = srch_q + SW'(1'b1);
            end
         end
         S_STEP: begin
            state_d = S_WAIT_PS;
            cnt_d   = CW'(1'b1);
         end
         S_WAIT_PS: begin
            if (psdone) begin
               phase_d = (offph_q && !OFF_DIR) ? phase_q - PW'(1'b1) : phase_q + PW'(1'b1);
               if (!offph_q) begin
                  state_d = S_SETTLE;
                  cnt_d   = '0;
               end else if (off_q == OW'(1'b1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_STEP;
                  off_d   = off_q - OW'(1'b1);
               end
            end else if (cnt_q == CW'(PS_TIMEOUT - 1)) begin
               state_d = S_FAIL;
               code_d  = 2'b10;
            end else begin
               cnt_d = cnt_q + CW'(1'b1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (lock_lost_s) begin
         state_d = S_FAIL;
         code_d  = 2'b11;
      end else begin
         code_d = code_d;
      end
   end

   // Output decode from the next state so every output is a plain flop
   always_comb begin
      psen_d     = (state_d == S_STEP);
      psincdec_d = psen_d ? (offph_d ? OFF_DIR : 1'b1) : 1'b0;
      busy_d     = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_FAIL);
      done_d     = (state_d == S_DONE);
      fail_d     = (state_d == S_FAIL);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ones_q     <= '0;
         srch_q     <= '0;
         off_q      <= '0;
         offph_q    <= 1'b0;
         prevz_q    <= 1'b0;
         phase_q    <= '0;
         code_q     <= 2'b00;
         psen_q     <= 1'b0;
         psincdec_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ones_q     <= ones_d;
         srch_q     <= srch_d;
         off_q      <= off_d;
         offph_q    <= offph_d;
         prevz_q    <= prevz_d;
         phase_q    <= phase_d;
         code_q     <= code_d;
         psen_q     <= psen_d;
         psincdec_q <= psincdec_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
      end
   end

   assign psen      = psen_q;
   assign psincdec  = psincdec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_code = code_q;
   assign phase_o   = phase_q;

endmodule

// File: tb/tb_clock_phase_align.sv
// Bench for clock_phase_align: two instances (offset 0 and -5) driven by a
// behavioural clock-manager model that returns psdone three cycles after psen.
module tb_clock_phase_align;

   localparam int PW  = 12;
   localparam int PSM = 40;
   localparam int TMO = 50;

   logic clk = 1'b0;
   logic rst_n, start, locked;
   logic sample [2];
   logic psdone [2];
   logic psen [2];
   logic psincdec [2];
   logic busy [2];
   logic done [2];
   logic fail [2];
   logic [1:0] code [2];
   logic [PW-1:0] phase [2];

   always #5 clk = ~clk;

   clock_phase_align #(.PS_MAX(PSM), .PW(PW), .SAMPLES(8), .SETTLE(4), .OFFSET(0), .PS_TIMEOUT(TMO)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .locked_i(locked), .sample_i(sample[0]),
      .psen(psen[0]), .psincdec(psincdec[0]), .psdone(psdone[0]), .busy(busy[0]),
      .done(done[0]), .fail(fail[0]), .fail_code(code[0]), .phase_o(phase[0]));

   clock_phase_align #(.PS_MAX(PSM), .PW(PW), .SAMPLES(8), .SETTLE(4), .OFFSET(-5), .PS_TIMEOUT(TMO)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .locked_i(locked), .sample_i(sample[1]),
      .psen(psen[1]), .psincdec(psincdec[1]), .psdone(psdone[1]), .busy(busy[1]),
      .done(done[1]), .fail(fail[1]), .fail_code(code[1]), .phase_o(phase[1]));

   // sample modes: 0 edge at edge_tap, 1 stuck 0, 2 toggling (tie), 3 high at tap 0 then edge
   int mode, edge_tap, cyc, first_psen;
   bit pd_en, clr;
   int tap [2];
   int pend [2];
   int npsen [2];
   int ndec [2];
   int nviol [2];
   logic dir_p [2];
   logic psen_prev [2];
   int total, bad;

   typedef struct {
      int mode; int edge_tap; int drop_tap;
      int pulses_a; int decs_a; int phase_a; int done_a; int fail_a; int code_a;
      int pulses_b; int decs_b; int phase_b; int done_b; int fail_b; int code_b;
   } vec_t;
   vec_t tbl [5];

   function automatic logic samp(input int t);
      case (mode)
         0: samp = (t >= edge_tap);
         1: samp = 1'b0;
         2: samp = cyc[0];
         default: samp = (t == 0) || (t >= edge_tap);
      endcase
   endfunction

   // Clock-manager model: one psdone per psen, tap follows psincdec
   initial begin
      cyc = 0;
      first_psen = -1;
      for (int k = 0; k < 2; k++) begin
         psdone[k] = 1'b0; sample[k] = 1'b0; tap[k] = 0; pend[k] = 0;
         npsen[k] = 0; ndec[k] = 0; nviol[k] = 0; psen_prev[k] = 1'b0; dir_p[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (clr) begin
               tap[k] = 0; pend[k] = 0; npsen[k] = 0; ndec[k] = 0; nviol[k] = 0;
               psdone[k] = 1'b0; psen_prev[k] = 1'b0;
               if (k == 0) first_psen = -1;
            end else begin
               if (psdone[k]) psdone[k] = 1'b0;
               if (pend[k] > 0) begin
                  pend[k]--;
                  if (pend[k] == 0) begin
                     psdone[k] = 1'b1;
                     tap[k] = tap[k] + (dir_p[k] ? 1 : -1);
                  end
               end
               if (psen[k] === 1'b1) begin
                  if (psen_prev[k] || pend[k] > 0 || psdone[k]) nviol[k]++;
                  npsen[k]++;
                  if (psincdec[k] !== 1'b1) ndec[k]++;
                  if (k == 0 && first_psen < 0) first_psen = cyc;
                  dir_p[k] = psincdec[k];
                  if (pd_en) pend[k] = 3;
               end
               psen_prev[k] = (psen[k] === 1'b1);
            end
            sample[k] = samp(tap[k]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clr = 1'b1;
      tick(); tick();
      clr = 1'b0; rst_n = 1'b1;
      tick();
   endtask

   task automatic check_zero(input int k, input string tag);
      chk($sformatf("%s_psen%0d", tag, k), 32'(psen[k]), 0);
      chk($sformatf("%s_psincdec%0d", tag, k), 32'(psincdec[k]), 0);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
      chk($sformatf("%s_done%0d", tag, k), 32'(done[k]), 0);
      chk($sformatf("%s_fail%0d", tag, k), 32'(fail[k]), 0);
      chk($sformatf("%s_code%0d", tag, k), 32'(code[k]), 0);
      chk($sformatf("%s_phase%0d", tag, k), 32'(phase[k]), 0);
   endtask

   task automatic check_dut(input int k, input int i, input int pul, input int dec, input int ph,
                            input int dn, input int fl, input int cd);
      chk($sformatf("v%0d_pulses%0d", i, k), npsen[k], pul);
      chk($sformatf("v%0d_decs%0d", i, k), ndec[k], dec);
      chk($sformatf("v%0d_phase%0d", i, k), 32'(phase[k]), ph);
      chk($sformatf("v%0d_done%0d", i, k), 32'(done[k]), dn);
      chk($sformatf("v%0d_fail%0d", i, k), 32'(fail[k]), fl);
      chk($sformatf("v%0d_code%0d", i, k), 32'(code[k]), cd);
      chk($sformatf("v%0d_busy%0d", i, k), 32'(busy[k]), 0);
      chk($sformatf("v%0d_protocol%0d", i, k), nviol[k], 0);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      bit   dropped;
      bit   fin;
      v = tbl[i];
      mode = v.mode; edge_tap = v.edge_tap; pd_en = 1'b1; locked = 1'b1;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      dropped = 1'b0; fin = 1'b0;
      for (int n = 0; n < 4000 && !fin; n++) begin
         tick();
         if (v.drop_tap >= 0 && !dropped && tap[0] == v.drop_tap) begin
            locked = 1'b0; dropped = 1'b1;
            tick();
            chk($sformatf("v%0d_lockloss_next_a", i), 32'(fail[0]), 1);
            chk($sformatf("v%0d_lockloss_next_b", i), 32'(fail[1]), 1);
         end
         if (!busy[0] && !busy[1]) fin = 1'b1;
      end
      chk($sformatf("v%0d_finished", i), 32'(fin), 1);
      check_dut(0, i, v.pulses_a, v.decs_a, v.phase_a, v.done_a, v.fail_a, v.code_a);
      check_dut(1, i, v.pulses_b, v.decs_b, v.phase_b, v.done_b, v.fail_b, v.code_b);
      locked = 1'b1;
   endtask

   initial begin
      bit fin;
      int fcyc;
      total = 0; bad = 0;
      rst_n = 1'b0; start = 1'b0; locked = 1'b1; clr = 1'b1; pd_en = 1'b1;
      mode = 1; edge_tap = 0;
      //            mode edge drop | A: pul dec ph dn fl cd | B: pul dec ph dn fl cd
      tbl[0] = '{0, 37, -1,  37, 0, 37, 1, 0, 0,  42, 5, 32, 1, 0, 0};
      tbl[1] = '{1,  0, -1,  40, 0, 40, 0, 1, 1,  40, 0, 40, 0, 1, 1};
      tbl[2] = '{2,  0, -1,  40, 0, 40, 0, 1, 1,  40, 0, 40, 0, 1, 1};
      tbl[3] = '{3,  5, -1,   5, 0,  5, 1, 0, 0,  10, 5,  0, 1, 0, 0};
      tbl[4] = '{0, 37, 10,  10, 0, 10, 0, 1, 3,  10, 0, 10, 0, 1, 3};

      tick(); tick();
      check_zero(0, "reset");
      check_zero(1, "reset");
      clr = 1'b0; rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(i);

      // psdone withheld: timeout fires exactly TMO cycles after the only psen
      mode = 1; pd_en = 1'b0; locked = 1'b1;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      fin = 1'b0; fcyc = 0;
      for (int n = 0; n < 400 && !fin; n++) begin
         tick();
         if (fail[0]) begin fin = 1'b1; fcyc = cyc; end
      end
      chk("tmo_reached", 32'(fin), 1);
      chk("tmo_latency", fcyc - first_psen, TMO);
      chk("tmo_code_a", 32'(code[0]), 2);
      chk("tmo_code_b", 32'(code[1]), 2);
      repeat (10) tick();
      chk("tmo_single_psen_a", npsen[0], 1);
      chk("tmo_single_psen_b", npsen[1], 1);
      chk("tmo_busy_a", 32'(busy[0]), 0);
      chk("tmo_phase_a", 32'(phase[0]), 0);

      // Reset while waiting for psdone, then a clean restart
      mode = 0; edge_tap = 37; pd_en = 1'b1;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      fin = 1'b0;
      for (int n = 0; n < 500 && !fin; n++) begin
         tick();
         if (npsen[0] >= 3) fin = 1'b1;
      end
      tick();
      chk("rstps_phase_before", 32'(phase[0]), 2);
      chk("rstps_busy_before", 32'(busy[0]), 1);
      rst_n = 1'b0; clr = 1'b1;
      tick();
      check_zero(0, "rstps");
      tick();
      clr = 1'b0; rst_n = 1'b1;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      fin = 1'b0;
      for (int n = 0; n < 4000 && !fin; n++) begin
         tick();
         if (!busy[0] && !busy[1]) fin = 1'b1;
      end
      chk("restart_finished", 32'(fin), 1);
      chk("restart_done_a", 32'(done[0]), 1);
      chk("restart_phase_a", 32'(phase[0]), 37);
      chk("restart_pulses_a", npsen[0], 37);
      chk("restart_phase_b", 32'(phase[1]), 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
